mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between three requesters:
  - instruction fetch (IF state of the multicycle controller)
  - data access (lw/sw MEM state)
  - debug/program loader
- Arbitrates one transaction at a time, drives the memory port, counts the fixed memory latency, returns read data with a one-cycle acknowledge.
- Sits between the control/datapath and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request, read only
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch done pulse
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data done pulse
- dbg_req  in  1  loader request
- dbg_we  in  1  loader write enable
- dbg_addr  in  ADDR_W  loader address
- dbg_wdata  in  DATA_W  loader write data
- dbg_ack  out  1  one-cycle loader done pulse
- rdata  out  DATA_W  read data, valid only in the ack cycle
- busy  out  1  transaction in flight (any state except IDLE)
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (RST=0, async):
  - state = IDLE.
  - All outputs 0: acks, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata.
  - Round-robin pointer last = 2 (dbg), so first priority order is IF, D, DBG.
  - An in-flight access is abandoned, mem_we drops immediately, no ack is issued after reset release.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the req lines each cycle.
  - If any are high, picks the winner by round-robin starting after last.
  - Latches winner id, we (IF forces 0), addr, wdata.
  - Sets mem_en=1 with the latched mem_we/mem_addr/mem_wdata, busy=1, cnt=MEM_LAT, goes to ISSUE.
- ISSUE:
  - mem_en is high this cycle only; mem_en=0 on exit.
  - Goes to WAIT; cnt decrements each WAIT cycle.
- WAIT:
  - When cnt reaches 1, rdata <= mem_rdata (for writes rdata <= 0).
  - Pulses the winner's ack and goes to RESP. Writes also wait MEM_LAT.
- RESP:
  - The ack and rdata are valid for exactly this cycle.
  - last <= winner, busy=0 on exit, return to IDLE.
  - No arbitration in RESP, so a requester has one cycle to drop req.
- mem_addr/mem_wdata hold their values from ISSUE through RESP.
- Latency: req sampled at edge T, mem_en in cycle T+1, ack in cycle T+MEM_LAT+2. Back-to-back rate is one transaction per MEM_LAT+3 cycles.
- Requester protocol: hold req/addr/we/wdata stable until ack.
  - A req dropped before being sampled in IDLE is ignored.
  - A req dropped after grant still completes and is still acked.
- Simultaneous requests: exactly one grant. The others wait and are served in rotation, so no starvation.
- A req held high through RESP is re-eligible in the next IDLE, but rotation places it last.
- Address and data pass unmodified; no alignment checks.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority D > IF > DBG. The data access always wins so a lw/sw in the MEM state is never delayed by fetch. The pointer last is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset then if_req=1, if_addr=0x00000004, MEM_LAT=1, mem_rdata=0xDEADBEEF -> mem_en in cycle 1 with mem_addr=0x4, mem_we=0; if_ack and rdata=0xDEADBEEF in cycle 3; busy low in cycle 4.
- d_req=1, d_we=1, d_addr=0x10, d_wdata=0x55 -> mem_en=1, mem_we=1, mem_wdata=0x55 for one cycle; d_ack after MEM_LAT+2; rdata=0.
- if_req, d_req, dbg_req all held high from reset -> grant order IF, D, DBG, IF…; acks spaced MEM_LAT+3 cycles apart. With MEM_ARB_FIXED_PRIO_EN: D, D, D… while d_req is held.
- MEM_LAT=4, d_req read -> ack exactly 6 cycles after the sampling edge; mem_addr stable throughout.
- RST asserted during WAIT -> all outputs 0 immediately; no ack after release; the next request is served normally with IF first priority.
- d_req pulsed high for one cycle while IF is in flight -> ignored, no d_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: fetch, data and debug loader share one memory macro.
// Optional MEM_ARB_FIXED_PRIO_EN selects fixed priority D > IF > DBG instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, next_state;
    logic [1:0]        winner;
    logic [1:0]        gnt;
    logic [3:0]        cnt;
    logic [2:0]        req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Requester ids: 0 = fetch, 1 = data, 2 = debug loader.
    assign req = {dbg_req, d_req, if_req};

`ifdef MEM_ARB_FIXED_PRIO_EN
    function automatic logic [1:0] pick_fixed(input logic [2:0] r);
        if (r[1])      return 2'd1;
        else if (r[0]) return 2'd0;
        else           return 2'd2;
    endfunction

    assign gnt = pick_fixed(req);
`else
    logic [1:0] last;

    // Scan from furthest to nearest so the requester right after lst wins.
    function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] lst);
        logic [1:0] idx;
        logic [1:0] res;
        res = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(lst) + k) % 3);
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    assign gnt = pick_rr(req, last);
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = '0;
        case (gnt)
            2'd1: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            2'd2: begin
                sel_we    = dbg_we;
                sel_addr  = dbg_addr;
                sel_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (|req) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT:  if (cnt == 4'd1) next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            winner    <= 2'd0;
            cnt       <= 4'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            dbg_ack   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last      <= 2'd2;
`endif
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            dbg_ack <= 1'b0;
            rdata   <= '0;
            mem_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner    <= gnt;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= 4'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        rdata   <= mem_we ? '0 : mem_rdata;
                        if_ack  <= (winner == 2'd0);
                        d_ack   <= (winner == 2'd1);
                        dbg_ack <= (winner == 2'd2);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last <= winner;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected acks plus per-scenario checks.
// A second instance with MEM_LAT=4 is exercised only by the latency scenario.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          if_req, d_req, d_we, dbg_req, dbg_we;
    logic [AW-1:0] if_addr, d_addr, dbg_addr;
    logic [DW-1:0] d_wdata, dbg_wdata;
    logic          rd_force;
    logic [DW-1:0] rd_val;

    logic          if_ack, d_ack, dbg_ack, busy, mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          if_ack4, d_ack4, dbg_ack4, busy4, mem_en4, mem_we4;
    logic [DW-1:0] rdata4, mem_wdata4, mem_rdata4;
    logic [AW-1:0] mem_addr4;

    assign mem_rdata  = rd_force ? rd_val : (mem_addr ^ 32'hC0DE_0000);
    assign mem_rdata4 = mem_addr4 ^ 32'hC0DE_0000;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .RST(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT4)) u_dut4 (
        .clk(clk), .RST(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack4),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack4), .rdata(rdata4), .busy(busy4), .mem_en(mem_en4), .mem_we(mem_we4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   sb_en        = 1'b1;

    // Scoreboard: every ack of the MEM_LAT=1 instance must match the oldest expectation.
    always begin
        logic [2:0] ack_vec;
        logic [2:0] exp_vec;
        exp_t       e;
        @(posedge clk);
        #1;
        ack_vec = {dbg_ack, d_ack, if_ack};
        if (sb_en && ack_vec != 3'b000) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_ack: acks(dbg,d,if)=%b rdata=%h, required no ack", ack_vec, rdata);
            end else begin
                e = sb_q.pop_front();
                exp_vec = 3'b001 << e.id;
                if (ack_vec !== exp_vec || rdata !== e.data) begin
                    tests_failed++;
                    $display("FAIL sb_ack: acks=%b rdata=%h, required acks=%b rdata=%h",
                             ack_vec, rdata, exp_vec, e.data);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic push_exp(input logic [1:0] id, input logic [DW-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; dbg_req = 0; d_we = 0; dbg_we = 0;
        if_addr = '0; d_addr = '0; dbg_addr = '0; d_wdata = '0; dbg_wdata = '0;
        rd_force = 0; rd_val = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        tests_run++;
        if ({if_ack, d_ack, dbg_ack, busy, mem_en, mem_we} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: acks/busy/en/we=%b, required 000000",
                     {if_ack, d_ack, dbg_ack, busy, mem_en, mem_we});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0", mem_addr, mem_wdata, rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_if_read();
        idle_inputs();
        do_reset();
        if_req = 1; if_addr = 32'h4; rd_force = 1; rd_val = 32'hDEAD_BEEF;
        push_exp(2'd0, 32'hDEAD_BEEF);
        cyc();
        tests_run++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h4}) begin
            tests_failed++;
            $display("FAIL if_issue: en=%b we=%b addr=%h, required en=1 we=0 addr=00000004", mem_en, mem_we, mem_addr);
        end
        cyc();
        tests_run++;
        if ({mem_en, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL if_wait: en=%b busy=%b, required en=0 busy=1", mem_en, busy);
        end
        cyc();
        tests_run++;
        if (if_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL if_ack_cycle3: if_ack=%b, required 1", if_ack);
        end
        if_req = 0;
        cyc();
        rd_force = 0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_busy_cycle4: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_d_write();
        int k;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h55;
        push_exp(2'd1, 32'h0);
        cyc();
        tests_run++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h10, 32'h55}) begin
            tests_failed++;
            $display("FAIL d_write_issue: en=%b we=%b addr=%h wdata=%h, required 1 1 00000010 00000055",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        cyc();
        tests_run++;
        if (mem_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL d_write_en_once: en=%b, required 0", mem_en);
        end
        k = 2;
        while (d_ack !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        tests_run++;
        if (k != LAT + 2) begin
            tests_failed++;
            $display("FAIL d_write_latency: ack at cycle %0d, required %0d", k, LAT + 2);
        end
        d_req = 0; d_we = 0;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0] ord [6];
        int n, acks, prev;
        logic [AW-1:0] adr;
        idle_inputs();
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_addr = 32'h200;
        dbg_req = 1; dbg_addr = 32'h300;
        do_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
        ord = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`else
        ord = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`endif
        for (int i = 0; i < 6; i++) begin
            adr = (ord[i] == 2'd0) ? 32'h100 : (ord[i] == 2'd1) ? 32'h200 : 32'h300;
            push_exp(ord[i], rd_of(adr));
        end
        n = 0; acks = 0; prev = 0;
        while (acks < 6 && n < 80) begin
            cyc();
            n++;
            if (if_ack || d_ack || dbg_ack) begin
                acks++;
                if (acks > 1) begin
                    tests_run++;
                    if (n - prev != LAT + 3) begin
                        tests_failed++;
                        $display("FAIL rr_spacing: ack gap %0d, required %0d", n - prev, LAT + 3);
                    end
                end
                prev = n;
                if (acks == 6) idle_inputs();
            end
        end
        tests_run++;
        if (acks != 6) begin
            tests_failed++;
            $display("FAIL rr_timeout: %0d acks seen, required 6", acks);
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_lat4();
        int ack_at;
        bit stable;
        logic [DW-1:0] got;
        sb_en = 0;
        idle_inputs();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h44;
        ack_at = 0; stable = 1; got = '0;
        for (int k = 1; k <= 12 && ack_at == 0; k++) begin
            cyc();
            if (mem_addr4 !== 32'h44) stable = 0;
            if (k == 1) begin
                tests_run++;
                if (mem_en4 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL lat4_issue: mem_en=%b, required 1", mem_en4);
                end
            end
            if (d_ack4 === 1'b1) begin
                ack_at = k;
                got = rdata4;
            end
        end
        d_req = 0;
        tests_run++;
        if (ack_at != LAT4 + 2) begin
            tests_failed++;
            $display("FAIL lat4_ack: ack at cycle %0d, required %0d", ack_at, LAT4 + 2);
        end
        tests_run++;
        if (got !== rd_of(32'h44)) begin
            tests_failed++;
            $display("FAIL lat4_rdata: rdata=%h, required %h", got, rd_of(32'h44));
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL lat4_addr_stable: mem_addr changed, required 00000044 throughout");
        end
        idle_inputs();
        do_reset();
        sb_en = 1;
    endtask

    task automatic test_reset_wait();
        int acks_seen, k;
        idle_inputs();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h77;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({if_ack, d_ack, dbg_ack, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL rst_in_wait: busy=%b we=%b addr=%h wdata=%h, required all 0",
                     busy, mem_we, mem_addr, mem_wdata);
        end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        acks_seen = 0;
        repeat (6) begin
            cyc();
            if (if_ack || d_ack || dbg_ack) acks_seen++;
        end
        tests_run++;
        if (acks_seen != 0) begin
            tests_failed++;
            $display("FAIL rst_no_ack: %0d acks after release, required 0", acks_seen);
        end
        if_req = 1; if_addr = 32'h30;
        d_req = 1; d_we = 0; d_addr = 32'h34;
`ifdef MEM_ARB_FIXED_PRIO_EN
        push_exp(2'd1, rd_of(32'h34));
`else
        push_exp(2'd0, rd_of(32'h30));
`endif
        k = 0;
        while (!(if_ack || d_ack || dbg_ack) && k < 20) begin
            cyc();
            k++;
        end
        tests_run++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if ({if_ack, d_ack} !== 2'b01) begin
`else
        if ({if_ack, d_ack} !== 2'b10) begin
`endif
            tests_failed++;
            $display("FAIL rst_first_grant: if_ack=%b d_ack=%b after %0d cycles", if_ack, d_ack, k);
        end
        idle_inputs();
        repeat (2) cyc();
    endtask

    task automatic test_drop_pulse();
        int k, dacks;
        idle_inputs();
        if_req = 1; if_addr = 32'h8;
        push_exp(2'd0, rd_of(32'h8));
        cyc();
        d_req = 1; d_we = 0; d_addr = 32'h50;
        cyc();
        d_req = 0;
        k = 0;
        while (if_ack !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        tests_run++;
        if (if_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_if_ack: if_ack=%b, required 1", if_ack);
        end
        if_req = 0;
        dacks = 0;
        repeat (8) begin
            cyc();
            if (d_ack) dacks++;
        end
        tests_run++;
        if (dacks != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_pulse: d_acks=%0d busy=%b, required 0 and 0", dacks, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_if_read();
        test_d_write();
        test_round_robin();
        test_lat4();
        test_reset_wait();
        test_drop_pulse();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected acks never seen, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
